// File: rtl/nibble_serial_adder_ctrl.sv
//==============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : W-bit add/subtract sequenced through one 4-bit ripple slice,
//               one nibble per clock, LSB first. Optional macro:
//               NIBBLE_ADDER_SUB_EN enables the sub_i (a - b) path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [4*NIBBLES-1:0]   a_i,
    input  logic [4*NIBBLES-1:0]   b_i,
    input  logic                   cin_i,
    input  logic                   sub_i,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [4*NIBBLES-1:0]   sum_o,
    output logic                   cout_o,
    output logic                   ovf_o
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      res_q;
    logic [W-1:0]      sum_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic              cout_q;
    logic              ovf_q;
    logic              done_q;

    logic [W-1:0]      w_b_in;
    logic              w_cin_in;
    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [4:0]        w_slice;
    logic [W-1:0]      w_res_d;
    logic              w_last;

`ifdef NIBBLE_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; cout then reads as "no borrow".
    assign w_b_in   = sub_i ? ~b_i : b_i;
    assign w_cin_in = sub_i ? 1'b1 : cin_i;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub_i;
    assign w_b_in       = b_i;
    assign w_cin_in     = cin_i;
`endif

    assign w_a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign w_b_nib = b_q[{idx_q, 2'b00} +: 4];
    assign w_slice = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, carry_q};
    assign w_last  = (idx_q == IDXW'(NIBBLES - 1));

    always_comb begin
        w_res_d = res_q;
        w_res_d[{idx_q, 2'b00} +: 4] = w_slice[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= w_b_in;
                        carry_q <= w_cin_in;
                        idx_q   <= '0;
                        res_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_q   <= w_res_d;
                    carry_q <= w_slice[4];
                    idx_q   <= idx_q + IDXW'(1);
                    if (w_last) begin
                        sum_q   <= w_res_d;
                        cout_q  <= w_slice[4];
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (w_slice[3] != a_q[W-1]);
                        done_q  <= 1'b1;
                        idx_q   <= '0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign busy_o  = ~ready_o;
    assign done_o  = done_q;
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
    assign ovf_o   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
//==============================================================================
// Module      : tb_nibble_serial_adder_ctrl
// Description : Scoreboard bench for nibble_serial_adder_ctrl (NIBBLES=4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_nibble_serial_adder_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         sub_i;
    logic         ready_o;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
        .sub_i   (sub_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the widened operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] bp;
        logic         cp;
        logic [W:0]   full;
        bp = b;
        cp = cin;
`ifdef NIBBLE_ADDER_SUB_EN
        if (sub) begin
            bp = ~b;
            cp = 1'b1;
        end
`endif
        full   = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, cp};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Monitor: every done pulse pops and compares one expected result.
    always @(negedge clk) begin
        if (!rst && done_o) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no result pending at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum",  sum_o, e.sum);
                check("cout", W'(cout_o), W'(e.cout));
                check("ovf",  W'(ovf_o),  W'(e.ovf));
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready_o) check("ready_timeout", W'(ready_o), W'(1));
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        @(negedge clk);
        wait_ready();
        a_i = a; b_i = b; cin_i = cin; sub_i = sub; start_i = 1'b1;
        sb_q.push_back(model(a, b, cin, sub));
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i = ~a; b_i = ~b;
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk);
            #1;
            check("done_timing", W'(done_o), W'(k == N));
            check("ready_timing", W'(ready_o), W'(k == N + 1));
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_ready", W'(ready_o), W'(1));
        check("rst_busy",  W'(busy_o),  W'(0));
        check("rst_done",  W'(done_o),  W'(0));
        check("rst_sum",   sum_o, '0);
        check("rst_cout",  W'(cout_o), W'(0));
        check("rst_ovf",   W'(ovf_o),  W'(0));
        rst = 1'b0;

        do_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        check("dir_sum_2345", sum_o, 16'h2345);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("dir_wrap_cout", W'(cout_o), W'(1));
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check("dir_ovf", W'(ovf_o), W'(1));
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1);
`ifdef NIBBLE_ADDER_SUB_EN
        check("dir_sub", sum_o, 16'hFFFE);
`else
        check("dir_nosub", sum_o, 16'h000C);
`endif

        for (int i = 0; i < 30; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

        // Start held high across RUN/DONE: second op accepted at E+6, done at E+10.
        @(negedge clk);
        wait_ready();
        a_i = 16'h0F0F; b_i = 16'h1010; cin_i = 1'b1; sub_i = 1'b0; start_i = 1'b1;
        sb_q.push_back(model(16'h0F0F, 16'h1010, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        a_i = 16'hABCD; b_i = 16'h1357; cin_i = 1'b0;
        sb_q.push_back(model(16'hABCD, 16'h1357, 1'b0, 1'b0));
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (k == 6) start_i = 1'b0;
            check("held_done", W'(done_o), W'(k == 4 || k == 10));
            if (k == 5) check("held_ready_e5", W'(ready_o), W'(1));
            if (k == 6) check("held_busy_e6",  W'(busy_o),  W'(1));
        end

        // Reset mid-RUN: no result pending, outputs back to reset values.
        @(negedge clk);
        wait_ready();
        a_i = 16'h4444; b_i = 16'h3333; cin_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_ready", W'(ready_o), W'(1));
        check("mrst_busy",  W'(busy_o),  W'(0));
        check("mrst_sum",   sum_o, '0);
        check("mrst_cout",  W'(cout_o), W'(0));
        check("mrst_ovf",   W'(ovf_o),  W'(0));
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("mrst_no_done", W'(done_o), W'(0));
        end

        do_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        check("post_rst_ovf", W'(ovf_o), W'(1));

        @(negedge clk);
        check("sb_empty", W'(sb_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
